// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_STEPS_DEFAULT = 32;

  // Quotient returned for a zero divisor before sign correction
  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_hilo_ctrl_if.sv
// EX-side bundle for the multiply/divide unit and HI/LO registers.
interface md_hilo_ctrl_if;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_flush;
  logic        hilo_use;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        md_busy;
  logic        md_done;
  logic        md_stall;

  modport master (
    output md_start, md_op, md_a, md_b, md_flush, hilo_use,
           mthi_we, mtlo_we, mt_data,
    input  hi_o, lo_o, md_busy, md_done, md_stall
  );

  modport slave (
    input  md_start, md_op, md_a, md_b, md_flush, hilo_use,
           mthi_we, mtlo_we, mt_data,
    output hi_o, lo_o, md_busy, md_done, md_stall
  );
endinterface

// File: rtl/md_iter_core.sv
// Iterative datapath: shift-add multiply / restoring divide on unsigned
// magnitudes, one bit per step, plus the step counter.
// acc layout: multiply -> {partial product hi, multiplier/product lo};
//             divide   -> {partial remainder, dividend/quotient}.
module md_iter_core #(
  parameter int unsigned MD_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [63:0] acc_init_i,
  input  logic [31:0] opnd_b_i,
  output logic [63:0] acc_o,
  output logic        last_o
);
  localparam int unsigned CW = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;

  logic [63:0]   acc_q;
  logic [31:0]   b_q;
  logic [CW-1:0] cnt_q;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] div_next;

  // Next accumulator value for one multiply or divide step
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    rem_sh   = {acc_q[63:32], acc_q[31]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (rem_diff[32]) begin
      div_next = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {rem_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Accumulator, operand and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= acc_init_i;
      b_q   <= opnd_b_i;
      cnt_q <= CW'(MD_STEPS - 1);
    end else if (step_i) begin
      acc_q <= is_div_i ? div_next : mul_next;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO register owner.
// Optional build macro: MD_FAST_MULT_EN (single-cycle multiplier for
// MULT/MULTU; divide keeps the iterative path).
module md_hilo_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MD_STEPS = MD_STEPS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  md_hilo_ctrl_if.slave bus
);
  md_state_t   state_q, state_d;
  md_op_t      op_q, start_op;
  logic        neg_res_q, neg_rem_q, bzero_q;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg, start_ok, step, last, commit;
  logic [31:0] abs_a, abs_b;
  logic [63:0] acc_init, acc;
  logic [63:0] prod;
  logic [31:0] quo, quo_s, rem_s;

  // Operand magnitudes for the unsigned datapath
  always_comb begin
    start_op = md_op_t'(bus.md_op);
    a_neg    = op_is_signed(start_op) & bus.md_a[31];
    b_neg    = op_is_signed(start_op) & bus.md_b[31];
    abs_a    = a_neg ? (32'd0 - bus.md_a) : bus.md_a;
    abs_b    = b_neg ? (32'd0 - bus.md_b) : bus.md_b;
    start_ok = (state_q == ST_IDLE) && bus.md_start && !bus.md_flush;
`ifdef MD_FAST_MULT_EN
    acc_init = op_is_div(start_op) ? {32'd0, abs_a}
                                   : ({32'd0, abs_a} * {32'd0, abs_b});
`else
    acc_init = {32'd0, abs_a};
`endif
  end

  assign step = (state_q == ST_CALC);

  md_iter_core #(.MD_STEPS(MD_STEPS)) u_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start_ok),
    .step_i     (step),
    .is_div_i   (op_is_div(op_q)),
    .acc_init_i (acc_init),
    .opnd_b_i   (abs_b),
    .acc_o      (acc),
    .last_o     (last)
  );

  // FSM next-state; flush overrides both start and commit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
`ifdef MD_FAST_MULT_EN
          state_d = op_is_div(start_op) ? ST_CALC : ST_FIX;
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (bus.md_flush)  state_d = ST_IDLE;
        else if (last)     state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign correction and HI/LO next values (commit or MTHI/MTLO in IDLE)
  always_comb begin
    commit = (state_q == ST_FIX) && !bus.md_flush;
    prod   = neg_res_q ? (64'd0 - acc) : acc;
    quo    = bzero_q ? MD_DIV0_Q : acc[31:0];
    quo_s  = neg_res_q ? (32'd0 - quo) : quo;
    rem_s  = neg_rem_q ? (32'd0 - acc[63:32]) : acc[63:32];
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = commit;
    if (commit) begin
      if (op_is_div(op_q)) begin
        hi_d = rem_s;
        lo_d = quo_s;
      end else begin
        hi_d = prod[63:32];
        lo_d = prod[31:0];
      end
    end else if (state_q == ST_IDLE) begin
      if (bus.mthi_we) hi_d = bus.mt_data;
      if (bus.mtlo_we) lo_d = bus.mt_data;
    end
  end

  // State, latched op/sign flags and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      if (start_ok) begin
        op_q      <= start_op;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        bzero_q   <= op_is_div(start_op) && (bus.md_b == '0);
      end
    end
  end

  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;
  assign bus.md_busy  = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.md_done  = done_q;
  assign bus.md_stall = bus.hilo_use & bus.md_busy;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed self-checking bench for md_hilo_ctrl (iterative build).
module tb_md_hilo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  md_hilo_ctrl_if bus();

  md_hilo_ctrl #(.MD_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output int done_n);
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = op; bus.md_a = a; bus.md_b = b;
    @(negedge clk);
    bus.md_start = 1'b0;
    busy_n = 0; done_n = 0;
    if (bus.md_busy) busy_n++;
    if (bus.md_done) done_n++;
    repeat (39) begin
      @(negedge clk);
      if (bus.md_busy) busy_n++;
      if (bus.md_done) done_n++;
    end
  endtask

  task automatic chk_op(input string name, input int busy_n, input int done_n,
                        input logic [31:0] hi_e, input logic [31:0] lo_e);
    checks++;
    if (busy_n !== 33) begin errors++; $display("FAIL %s busy_cycles got %0d exp 33", name, busy_n); end
    checks++;
    if (done_n !== 1) begin errors++; $display("FAIL %s done_pulses got %0d exp 1", name, done_n); end
    checks++;
    if (bus.hi_o !== hi_e) begin errors++; $display("FAIL %s hi got %h exp %h", name, bus.hi_o, hi_e); end
    checks++;
    if (bus.lo_o !== lo_e) begin errors++; $display("FAIL %s lo got %h exp %h", name, bus.lo_o, lo_e); end
  endtask

  task automatic test_reset;
    bus.md_start = 0; bus.md_op = 0; bus.md_a = 0; bus.md_b = 0; bus.md_flush = 0;
    bus.hilo_use = 1; bus.mthi_we = 0; bus.mtlo_we = 0; bus.mt_data = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo_o); end
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.md_busy); end
    checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.md_done); end
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.md_stall); end
    rst = 1'b0;
    bus.hilo_use = 0;
  endtask

  task automatic test_mult;
    int bn, dn;
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bn, dn);
    chk_op("multu_max", bn, dn, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, bn, dn);
    chk_op("mult_neg", bn, dn, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
  endtask

  task automatic test_div;
    int bn, dn;
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, bn, dn);
    chk_op("div_neg", bn, dn, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(2'd3, 32'd100, 32'd0, bn, dn);
    chk_op("divu_zero", bn, dn, 32'd100, 32'hFFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn);
    chk_op("div_ovf", bn, dn, 32'd0, 32'h8000_0000);
    do_op(2'd2, 32'hFFFF_FFFB, 32'd0, bn, dn);
    chk_op("div_zero_neg", bn, dn, 32'hFFFF_FFFB, 32'd1);
  endtask

  task automatic test_stall;
    int sn = 0;
    logic prev = 1'b0, seen = 1'b0;
    logic [31:0] hi_rel = '0;
    bus.hilo_use = 1'b1;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 2'd2; bus.md_a = 32'd17; bus.md_b = 32'd5;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (40) begin
      if (bus.md_stall) sn++;
      if (!bus.md_stall && prev && !seen) begin seen = 1'b1; hi_rel = bus.hi_o; end
      prev = bus.md_stall;
      @(negedge clk);
    end
    bus.hilo_use = 1'b0;
    checks++; if (sn !== 33) begin errors++; $display("FAIL stall_cycles got %0d exp 33", sn); end
    checks++; if (hi_rel !== 32'd2) begin errors++; $display("FAIL stall_release_hi got %h exp 2", hi_rel); end
  endtask

  task automatic test_flush;
    int dn = 0, bn = 0;
    @(negedge clk);
    bus.mthi_we = 1; bus.mtlo_we = 0; bus.mt_data = 32'h11;
    @(negedge clk);
    bus.mthi_we = 0; bus.mtlo_we = 1; bus.mt_data = 32'h22;
    @(negedge clk);
    bus.mtlo_we = 0;
    bus.md_start = 1'b1; bus.md_op = 2'd3; bus.md_a = 32'd1000; bus.md_b = 32'd3;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b exp 1", bus.md_busy); end
    bus.md_flush = 1'b1;
    @(negedge clk);
    bus.md_flush = 1'b0;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL flush_idle got busy %b exp 0", bus.md_busy); end
    repeat (40) begin
      @(negedge clk);
      if (bus.md_done) dn++;
      if (bus.md_busy) bn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL flush_done got %0d exp 0", dn); end
    checks++; if (bus.hi_o !== 32'h11) begin errors++; $display("FAIL flush_hi got %h exp 11", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h22) begin errors++; $display("FAIL flush_lo got %h exp 22", bus.lo_o); end
  endtask

  task automatic test_idle_flush_start;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_flush = 1'b1; bus.md_op = 2'd1; bus.md_a = 32'd9; bus.md_b = 32'd9;
    @(negedge clk);
    bus.md_start = 1'b0; bus.md_flush = 1'b0;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL idle_flush_busy got %b exp 0", bus.md_busy); end
    repeat (40) @(negedge clk);
    checks++; if (bus.lo_o !== 32'h22) begin errors++; $display("FAIL idle_flush_lo got %h exp 22", bus.lo_o); end
  endtask

  task automatic test_mt_both;
    @(negedge clk);
    bus.mthi_we = 1; bus.mtlo_we = 1; bus.mt_data = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.mthi_we = 0; bus.mtlo_we = 0;
    checks++; if (bus.hi_o !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mt_both_hi got %h exp a5a50f0f", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'hA5A5_0F0F) begin errors++; $display("FAIL mt_both_lo got %h exp a5a50f0f", bus.lo_o); end
  endtask

  task automatic test_back_to_back;
    int  i;
    logic got = 1'b0;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 2'd1; bus.md_a = 32'd6; bus.md_b = 32'd7;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 2'd3; bus.md_a = 32'd1; bus.md_b = 32'd1;
    @(negedge clk);
    bus.md_start = 1'b0;
    for (i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.md_done) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_done_timeout got 0 exp 1"); end
    checks++; if (bus.lo_o !== 32'd42) begin errors++; $display("FAIL b2b_first_lo got %h exp 2a", bus.lo_o); end
    bus.md_start = 1'b1; bus.md_op = 2'd3; bus.md_a = 32'd100; bus.md_b = 32'd7;
    @(negedge clk);
    bus.md_start = 1'b0;
    checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b exp 1", bus.md_busy); end
    repeat (40) @(negedge clk);
    checks++; if (bus.hi_o !== 32'd2) begin errors++; $display("FAIL b2b_second_hi got %h exp 2", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'd14) begin errors++; $display("FAIL b2b_second_lo got %h exp e", bus.lo_o); end
  endtask

  task automatic test_reset_mid;
    bus.hilo_use = 1'b1;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 2'd1; bus.md_a = 32'd123; bus.md_b = 32'd456;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_stall got %b exp 1", bus.md_stall); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", bus.md_busy); end
    checks++; if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", bus.md_stall); end
    checks++; if (bus.hi_o !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h exp 0", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h exp 0", bus.lo_o); end
    checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", bus.md_done); end
    @(negedge clk);
    rst = 1'b0; bus.hilo_use = 1'b0;
    @(negedge clk);
    bus.mthi_we = 1'b1; bus.mt_data = 32'h5A;
    @(negedge clk);
    bus.mthi_we = 1'b0;
    checks++; if (bus.hi_o !== 32'h5A) begin errors++; $display("FAIL rst_mthi_hi got %h exp 5a", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'd0) begin errors++; $display("FAIL rst_mthi_lo got %h exp 0", bus.lo_o); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_flush();
    test_idle_flush_start();
    test_mt_both();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
